// File: rtl/axi_ram_reader.sv
// Streams a contiguous, wrapping block of words from a synchronous-read RAM onto an
// AXI-stream output through a two-entry registered buffer.
module axi_ram_reader #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned AWIDTH = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [AWIDTH-1:0] cmd_addr,
  input  logic [AWIDTH-1:0] cmd_len,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  output logic              ram_en,
  output logic [AWIDTH-1:0] ram_addr,
  input  logic [WIDTH-1:0]  ram_dout,
  output logic [WIDTH-1:0]  o_tdata,
  output logic              o_tlast,
  output logic              o_tvalid,
  input  logic              o_tready,
  output logic              busy,
  output logic [15:0]       words_sent
);

  typedef enum logic [1:0] {StIdle, StReading, StDraining} state_e;

  localparam logic [AWIDTH-1:0] AddrOne = 1;
  localparam logic [AWIDTH:0]   RemOne  = 1;

  state_e            state_q, state_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [AWIDTH:0]   remain_q, remain_d;
  logic              inflight_q, inflight_d;
  logic              inflight_last_q, inflight_last_d;
  logic              head_vld_q, head_vld_d;
  logic              head_last_q, head_last_d;
  logic [WIDTH-1:0]  head_data_q, head_data_d;
  logic              tail_vld_q, tail_vld_d;
  logic              tail_last_q, tail_last_d;
  logic [WIDTH-1:0]  tail_data_q, tail_data_d;
  logic [15:0]       words_q, words_d;

  logic       pop;
  logic       push;
  logic [1:0] level;
  logic       issue_ok;

  assign pop  = head_vld_q & o_tready;
  assign push = inflight_q;

  // Buffered words plus the outstanding read, less the word leaving this cycle.
  assign level    = {1'b0, head_vld_q} + {1'b0, tail_vld_q} + {1'b0, inflight_q};
  assign issue_ok = (level - {1'b0, pop}) < 2'd2;

  assign ram_en     = (state_q == StReading) & (remain_q != '0) & issue_ok & ~clear;
  assign ram_addr   = addr_q;
  assign cmd_ready  = (state_q == StIdle) & reset;
  assign busy       = (state_q != StIdle);
  assign o_tvalid   = head_vld_q;
  assign o_tdata    = head_data_q;
  assign o_tlast    = head_last_q;
  assign words_sent = words_q;

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    remain_d        = remain_q;
    inflight_d      = ram_en;
    inflight_last_d = ram_en & (remain_q == RemOne);
    head_vld_d      = head_vld_q;
    head_last_d     = head_last_q;
    head_data_d     = head_data_q;
    tail_vld_d      = tail_vld_q;
    tail_last_d     = tail_last_q;
    tail_data_d     = tail_data_q;
    words_d         = words_q + {15'd0, pop};

    unique case (state_q)
      StIdle: begin
        if (cmd_valid && cmd_ready) begin
          addr_d   = cmd_addr;
          remain_d = {1'b0, cmd_len} + RemOne;
          state_d  = StReading;
        end
      end
      StReading: begin
        if (ram_en) begin
          addr_d   = addr_q + AddrOne;
          remain_d = remain_q - RemOne;
          if (remain_q == RemOne) state_d = StDraining;
        end
      end
      StDraining: begin
        if (pop && head_last_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (pop) begin
      if (tail_vld_q) begin
        head_data_d = tail_data_q;
        head_last_d = tail_last_q;
        tail_vld_d  = push;
        tail_data_d = ram_dout;
        tail_last_d = inflight_last_q;
      end else begin
        head_vld_d  = push;
        head_data_d = ram_dout;
        head_last_d = push & inflight_last_q;
      end
    end else if (push) begin
      if (!head_vld_q) begin
        head_vld_d  = 1'b1;
        head_data_d = ram_dout;
        head_last_d = inflight_last_q;
      end else begin
        tail_vld_d  = 1'b1;
        tail_data_d = ram_dout;
        tail_last_d = inflight_last_q;
      end
    end

    // Abort wins over any command, issue or handshake in the same cycle.
    if (clear) begin
      state_d         = StIdle;
      remain_d        = '0;
      inflight_d      = 1'b0;
      inflight_last_d = 1'b0;
      head_vld_d      = 1'b0;
      head_last_d     = 1'b0;
      tail_vld_d      = 1'b0;
      tail_last_d     = 1'b0;
      words_d         = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= StIdle;
      addr_q          <= '0;
      remain_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      head_vld_q      <= 1'b0;
      head_last_q     <= 1'b0;
      head_data_q     <= '0;
      tail_vld_q      <= 1'b0;
      tail_last_q     <= 1'b0;
      tail_data_q     <= '0;
      words_q         <= '0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      remain_q        <= remain_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      head_vld_q      <= head_vld_d;
      head_last_q     <= head_last_d;
      head_data_q     <= head_data_d;
      tail_vld_q      <= tail_vld_d;
      tail_last_q     <= tail_last_d;
      tail_data_q     <= tail_data_d;
      words_q         <= words_d;
    end
  end

endmodule

// File: tb/tb_axi_ram_reader.sv
// Randomised scoreboard bench for axi_ram_reader: a RAM model, a per-word expectation
// queue built from the command alone, and a negedge monitor that pops and compares.
module tb_axi_ram_reader;

  localparam int W     = 32;
  localparam int AW    = 9;
  localparam int DEPTH = 512;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          clear = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [AW-1:0] cmd_len = '0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          ram_en;
  logic [AW-1:0] ram_addr;
  logic [W-1:0]  ram_dout = '0;
  logic [W-1:0]  o_tdata;
  logic          o_tlast;
  logic          o_tvalid;
  logic          o_tready = 1'b1;
  logic          busy;
  logic [15:0]   words_sent;

  logic [W-1:0]  mem [DEPTH];
  logic [W:0]    exp_q [$];
  logic [AW-1:0] addr_q [$];

  int          n_pass = 0;
  int          n_total = 0;
  int          n_pop = 0;
  logic [15:0] ws_model = '0;
  bit          rdy_rand = 1'b0;

  axi_ram_reader #(.WIDTH(W), .AWIDTH(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .cmd_addr   (cmd_addr),
    .cmd_len    (cmd_len),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .ram_en     (ram_en),
    .ram_addr   (ram_addr),
    .ram_dout   (ram_dout),
    .o_tdata    (o_tdata),
    .o_tlast    (o_tlast),
    .o_tvalid   (o_tvalid),
    .o_tready   (o_tready),
    .busy       (busy),
    .words_sent (words_sent)
  );

  initial forever #5 clk = ~clk;

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Synchronous-read RAM: data appears the cycle after ram_en.
  initial forever begin
    @(posedge clk);
    if (ram_en) ram_dout <= mem[ram_addr];
  end

  initial forever begin
    @(posedge clk);
    #1;
    o_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: every negedge, compares what will happen at the next rising edge.
  initial begin
    bit         prev_stall = 1'b0;
    bit         last_prev = 1'b0;
    logic [W-1:0] prev_data = '0;
    logic       prev_last = 1'b0;
    logic [W:0] e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_stall = 1'b0;
        last_prev  = 1'b0;
        ws_model   = '0;
      end else begin
        check("words_sent", 64'(words_sent), 64'(ws_model));
        if (last_prev) begin
          check("busy_after_last", 64'(busy), 64'(0));
          check("ready_after_last", 64'(cmd_ready), 64'(1));
        end
        if (prev_stall) begin
          check("stall_valid", 64'(o_tvalid), 64'(1));
          check("stall_data", 64'(o_tdata), 64'(prev_data));
          check("stall_last", 64'(o_tlast), 64'(prev_last));
        end
        last_prev = 1'b0;
        if (!clear && ram_en) begin
          if (addr_q.size() == 0) check("ram_en_extra", 64'(addr_q.size()), 64'(1));
          else check("ram_addr", 64'(ram_addr), 64'(addr_q.pop_front()));
        end
        if (clear) begin
          ws_model   = '0;
          prev_stall = 1'b0;
        end else begin
          if (o_tvalid && o_tready) begin
            n_pop++;
            ws_model++;
            if (exp_q.size() == 0) check("word_extra", 64'(exp_q.size()), 64'(1));
            else begin
              e = exp_q.pop_front();
              check("tdata", 64'(o_tdata), 64'(e[W-1:0]));
              check("tlast", 64'(o_tlast), 64'(e[W]));
              last_prev = e[W];
            end
          end
          prev_stall = o_tvalid && !o_tready;
          prev_data  = o_tdata;
          prev_last  = o_tlast;
        end
      end
    end
  end

  // Drives a command; expectations are queued on the cycle the handshake is seen.
  task automatic send_cmd(input logic [AW-1:0] a, input logic [AW-1:0] l);
    int t = 0;
    int idx;
    cmd_addr  = a;
    cmd_len   = l;
    cmd_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (cmd_ready) break;
      t++;
      if (t > 2000) break;
    end
    check("cmd_accept", 64'(cmd_ready), 64'(1));
    if (cmd_ready) begin
      for (int i = 0; i <= int'(l); i++) begin
        idx = (int'(a) + i) % DEPTH;
        exp_q.push_back({(i == int'(l)), mem[idx]});
        addr_q.push_back(AW'(idx));
      end
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp_q.size() != 0 || addr_q.size() != 0) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check("drain_in_time", 64'(t < 5000), 64'(1));
    @(posedge clk);
    #1;
  endtask

  // Called right after the handshake edge with the buffer empty and o_tready high.
  task automatic check_latency_rate(input int len);
    @(negedge clk);
    check("lat_cycle1", 64'(o_tvalid), 64'(0));
    @(negedge clk);
    check("lat_cycle2", 64'(o_tvalid), 64'(0));
    @(negedge clk);
    check("lat_rise", 64'(o_tvalid), 64'(1));
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      check("no_bubble", 64'(o_tvalid), 64'(1));
    end
  endtask

  task automatic check_reset_values();
    check("rst_cmd_ready", 64'(cmd_ready), 64'(0));
    check("rst_ram_en", 64'(ram_en), 64'(0));
    check("rst_ram_addr", 64'(ram_addr), 64'(0));
    check("rst_tvalid", 64'(o_tvalid), 64'(0));
    check("rst_tlast", 64'(o_tlast), 64'(0));
    check("rst_tdata", 64'(o_tdata), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_words", 64'(words_sent), 64'(0));
  endtask

  initial begin
    int base;
    int t;
    logic [AW-1:0] ra;
    logic [AW-1:0] rl;
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;

    repeat (3) @(posedge clk);
    #1;
    check_reset_values();
    reset = 1'b1;
    #1;
    check("ready_after_reset", 64'(cmd_ready), 64'(1));
    @(posedge clk);
    #1;

    // Basic 4-word burst, full rate; first transfer since reset so words_sent ends at 4.
    send_cmd(9'h010, 9'd3);
    check_latency_rate(3);
    wait_drain();
    @(negedge clk);
    check("words_after_first", 64'(words_sent), 64'(4));
    @(posedge clk);
    #1;

    // Address wrap at the top of the region.
    send_cmd(9'h1FE, 9'd3);
    check_latency_rate(3);
    wait_drain();

    // Single-word transfer.
    send_cmd(9'h0A5, 9'd0);
    check_latency_rate(0);
    wait_drain();

    // Full-region transfer with random back-pressure.
    rdy_rand = 1'b1;
    send_cmd(9'($urandom_range(0, DEPTH - 1)), 9'd511);
    wait_drain();

    // Clear after five words, then a fresh command.
    rdy_rand = 1'b0;
    base = n_pop;
    send_cmd(9'h040, 9'd19);
    t = 0;
    while (n_pop < base + 5 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("clear_reached_5", 64'(n_pop >= base + 5), 64'(1));
    @(posedge clk);
    #1;
    clear = 1'b1;
    exp_q.delete();
    addr_q.delete();
    @(posedge clk);
    #1;
    clear = 1'b0;
    @(negedge clk);
    check("clear_tvalid", 64'(o_tvalid), 64'(0));
    check("clear_words", 64'(words_sent), 64'(0));
    check("clear_busy", 64'(busy), 64'(0));
    @(posedge clk);
    #1;
    send_cmd(9'h100, 9'd7);
    check_latency_rate(7);
    wait_drain();

    // Asynchronous reset in the middle of a stalled transfer.
    rdy_rand = 1'b1;
    base = n_pop;
    send_cmd(9'h080, 9'd30);
    t = 0;
    while (n_pop < base + 3 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("reset_reached_3", 64'(n_pop >= base + 3), 64'(1));
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_reset_values();
    exp_q.delete();
    addr_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    send_cmd(9'h1F0, 9'd15);
    wait_drain();

    // Random commands, random back-pressure.
    for (int k = 0; k < 10; k++) begin
      rdy_rand = 1'($urandom_range(0, 1));
      ra = 9'($urandom_range(0, DEPTH - 1));
      rl = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, DEPTH - 1))
                                       : 9'($urandom_range(0, 15));
      send_cmd(ra, rl);
      wait_drain();
    end

    check("end_words_empty", 64'(exp_q.size()), 64'(0));
    check("end_addrs_empty", 64'(addr_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/axi_ram_reader.md
AXI_RAM_READER -- requirements
Module: axi_ram_reader

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning data word width in bits.
REQ-002 SHALL have parameter AWIDTH, default 9, meaning RAM address width; region size 2^AWIDTH words.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous assert, active-low (0 = in reset).
REQ-005 SHALL have port clear  input  1  synchronous abort, active-high.
REQ-006 SHALL have port cmd_addr  input  AWIDTH  start address of transfer.
REQ-007 SHALL have port cmd_len  input  AWIDTH  transfer length minus one, in words.
REQ-008 SHALL have ports cmd_valid  input  1  and cmd_ready  output  1  command handshake.
REQ-009 SHALL have ports ram_en  output  1  and ram_addr  output  AWIDTH  RAM read request.
REQ-010 SHALL have port ram_dout  input  WIDTH  RAM read data, valid exactly one cycle after ram_en.
REQ-011 SHALL have ports o_tdata  output  WIDTH, o_tlast  output  1, o_tvalid  output  1, o_tready  input  1  AXI-stream output.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-013 SHALL have port words_sent  output  16  count of output handshakes, diagnostic.

Function
REQ-014 SHALL implement states IDLE, READING, DRAINING.
REQ-015 SHALL assert cmd_ready only in IDLE; command accepted on cmd_valid & cmd_ready.
REQ-016 On accept SHALL latch next-issue address = cmd_addr and issue-remaining = cmd_len+1, and go to READING.
REQ-017 SHALL transfer exactly cmd_len+1 words (1 to 2^AWIDTH), reading addresses cmd_addr, cmd_addr+1, ..., modulo 2^AWIDTH.
REQ-018 SHALL wrap ram_addr from 2^AWIDTH-1 to 0 with no gap or error.
REQ-019 SHALL hold read data in a 2-entry output buffer, o_tdata/o_tlast/o_tvalid driven from its head entry registered, no combinational path from ram_dout or o_tready to o_tvalid/o_tdata.
REQ-020 SHALL assert ram_en only in READING, when issue-remaining > 0 and (buffer occupancy + reads in flight - pop this cycle) < 2; never overflow the buffer.
REQ-021 SHALL write ram_dout into the buffer on the cycle after each ram_en.
REQ-022 First o_tvalid SHALL rise 2 cycles after the command handshake cycle.
REQ-023 With o_tready held high SHALL sustain one word per cycle (no bubbles) for the whole transfer.
REQ-024 o_tdata/o_tlast SHALL remain stable while o_tvalid=1 and o_tready=0.
REQ-025 o_tlast SHALL be 1 exactly on the final word of each transfer.
REQ-026 SHALL move READING -> DRAINING when the last ram_en issues; DRAINING -> IDLE on the o_tlast handshake.
REQ-027 Next command SHALL be accepted no earlier than the cycle after the o_tlast handshake (one-cycle bubble between transfers).
REQ-028 words_sent SHALL increment by 1 on each o_tvalid & o_tready, wrapping at 2^16.
REQ-029 clear SHALL, in any state, return to IDLE next cycle, empty the buffer, discard in-flight read data, zero words_sent; o_tvalid low the next cycle; takes priority over simultaneous command or handshake.

Reset
REQ-030 While reset=0 SHALL force: state IDLE, cmd_ready=0 during reset and 1 after, ram_en=0, ram_addr=0, o_tvalid=0, o_tlast=0, o_tdata=0, busy=0, words_sent=0.
REQ-031 Reset asserted mid-transfer SHALL abort immediately (asynchronous); no word from the aborted transfer emitted after release.

Verification
REQ-032 cmd_addr=0x010, cmd_len=3, o_tready=1 -> RAM words 0x010..0x013 out on 4 consecutive cycles from cycle+2, o_tlast on 4th, words_sent=4.
REQ-033 cmd_addr=0x1FE, cmd_len=3 (AWIDTH=9) -> ram_addr 0x1FE,0x1FF,0x000,0x001 in order, 4 words out.
REQ-034 cmd_len=0 -> single word with o_tlast=1; busy low the cycle after handshake; cmd_ready high again.
REQ-035 o_tready toggled randomly over cmd_len=511 -> all 512 words in order, stable data while stalled, no loss, no duplication.
REQ-036 clear pulsed after 5 of 20 words -> o_tvalid low next cycle, words_sent=0, next command streams from its own cmd_addr with no stale data.
REQ-037 reset=0 asserted mid-transfer for 1 cycle -> all outputs at reset values immediately; after release only the new command's words appear.
